// File: rtl/washing_machine_pkg.sv
// Shared types and defaults for the washing machine panel front end.
// Holds the panel FSM encoding and the default wash prices.
package washing_machine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2
  } panel_state_e;

  localparam int unsigned PRICE_SINGLE_DEF = 2;
  localparam int unsigned PRICE_DOUBLE_DEF = 3;

endpackage

// File: rtl/wm_rise_detect.sv
// Registered history of a synchronous level with a rising-edge output.
// A level already high through reset reads as a rise right after reset.
module wm_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/wash_coin_panel.sv
// Coin acceptor and front panel driving the washer controller requests.
// Tracks credit, charges on start, and follows the wash cycle to done.
module wash_coin_panel
  import washing_machine_pkg::*;
#(
  parameter int unsigned CREDIT_W     = 4,
  parameter int unsigned PRICE_SINGLE = PRICE_SINGLE_DEF,
  parameter int unsigned PRICE_DOUBLE = PRICE_DOUBLE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_det,
  input  logic                start_btn,
  input  logic                sel_double,
  input  logic                pause_btn,
  input  logic                wash_done,
  output logic                coin_in,
  output logic                double_wash,
  output logic                timer_pause,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic                done_pulse,
  output logic                insufficient
);

  localparam int unsigned CW = CREDIT_W + 1;
  localparam logic [CW-1:0] CMAX = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [CW-1:0] P_S  = CW'(PRICE_SINGLE);
  localparam logic [CW-1:0] P_D  = CW'(PRICE_DOUBLE);

  logic coin_rise;
  logic start_rise;
  logic pause_rise;
  logic done_rise;

  wm_rise_detect u_coin (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (coin_det),
    .rise_o (coin_rise)
  );

  wm_rise_detect u_start (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (start_btn),
    .rise_o (start_rise)
  );

  wm_rise_detect u_pause (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (pause_btn),
    .rise_o (pause_rise)
  );

  wm_rise_detect u_done (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (wash_done),
    .rise_o (done_rise)
  );

  panel_state_e        state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                dbl_q, dbl_d;
  logic                pause_q, pause_d;
  logic                done_q, done_d;
  logic                insuf_q, insuf_d;

  logic [CW-1:0] sum_w;
  logic [CW-1:0] eff_w;
  logic [CW-1:0] price_w;

  // One extra bit so a coin on a full counter is caught before wrapping.
  assign sum_w   = {1'b0, credit_q} + CW'(coin_rise);
  assign eff_w   = (sum_w > CMAX) ? CMAX : sum_w;
  assign price_w = sel_double ? P_D : P_S;

  always_comb begin
    state_d  = state_q;
    credit_d = CREDIT_W'(eff_w);
    dbl_d    = dbl_q;
    pause_d  = pause_q;
    done_d   = 1'b0;
    insuf_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        pause_d = 1'b0;
        if (start_rise) begin
          if (eff_w >= price_w) begin
            credit_d = CREDIT_W'(eff_w - price_w);
            dbl_d    = sel_double;
            state_d  = ST_ISSUE;
          end else begin
            insuf_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        pause_d = 1'b0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // Completion outranks a same-cycle pause toggle.
        if (done_rise) begin
          pause_d = 1'b0;
          dbl_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (pause_rise) begin
          pause_d = ~pause_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      dbl_q    <= 1'b0;
      pause_q  <= 1'b0;
      done_q   <= 1'b0;
      insuf_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      dbl_q    <= dbl_d;
      pause_q  <= pause_d;
      done_q   <= done_d;
      insuf_q  <= insuf_d;
    end
  end

  assign coin_in      = (state_q == ST_ISSUE);
  assign busy         = (state_q != ST_IDLE);
  assign double_wash  = dbl_q;
  assign timer_pause  = pause_q;
  assign credit       = credit_q;
  assign done_pulse   = done_q;
  assign insufficient = insuf_q;

endmodule
